// File: rtl/main.sv
// Single-cycle accumulator CPU: 11-bit PC fetches 16-bit instructions, one ACC, HLT freezes until reset.
// Build option MAIN_SIGN_EXTEND_EN: sign-extend the 11-bit immediate instead of zero-extending it.
module main (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] Addr,
  input  logic [15:0] Data,
  output logic        WrRam,
  output logic        RdRam,
  output logic [10:0] Addr_DM,
  output logic [15:0] In_Data,
  input  logic [15:0] Out_Data
);

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [15:0] acc_q, acc_d;
  opcode_e     opcode;
  logic [10:0] operand;
  logic [15:0] imm;
  logic        running;

  assign opcode  = opcode_e'(Data[15:11]);
  assign operand = Data[10:0];
  assign running = (state_q == ST_RUN);

`ifdef MAIN_SIGN_EXTEND_EN
  assign imm = {{5{operand[10]}}, operand};
`else
  assign imm = {5'b0, operand};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (running && opcode == OP_HLT) state_d = ST_HALT;
  end

  // Halted or executing HLT: PC and ACC hold; undefined opcodes just advance the PC.
  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    if (running && opcode != OP_HLT) begin
      pc_d = pc_q + 11'd1;
      case (opcode)
        OP_LD:   acc_d = Out_Data;
        OP_LDI:  acc_d = imm;
        OP_ADD:  acc_d = acc_q + Out_Data;
        OP_ADDI: acc_d = acc_q + imm;
        OP_SUB:  acc_d = acc_q - Out_Data;
        OP_SUBI: acc_d = acc_q - imm;
        default: acc_d = acc_q;
      endcase
    end
  end

  // Strobes are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (running && rst_n) begin
      case (opcode)
        OP_STO:                WrRam = 1'b1;
        OP_LD, OP_ADD, OP_SUB: RdRam = 1'b1;
        default: ;
      endcase
    end
  end

  assign Addr    = pc_q;
  assign Addr_DM = operand;
  assign In_Data = acc_q;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for main: vector table with a scoreboard of expected PC/ACC, plus reset, halt and PC-wrap sequences.
module tb_main;

  logic        clk;
  logic        rst_n;
  logic [10:0] Addr;
  logic [15:0] Data;
  logic        WrRam;
  logic        RdRam;
  logic [10:0] Addr_DM;
  logic [15:0] In_Data;
  logic [15:0] Out_Data;

  main dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Addr     (Addr),
    .Data     (Data),
    .WrRam    (WrRam),
    .RdRam    (RdRam),
    .Addr_DM  (Addr_DM),
    .In_Data  (In_Data),
    .Out_Data (Out_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] out_data;
    logic        exp_wr;
    logic        exp_rd;
    logic [15:0] exp_acc;
  } vec_t;

  typedef struct {
    logic [10:0] pc;
    logic [15:0] acc;
  } exp_t;

`ifdef MAIN_SIGN_EXTEND_EN
  localparam logic [15:0] LDI_7FF_EXP  = 16'hFFFF;
  localparam logic [15:0] ADDI_7FF_EXP = 16'hFFFE;
`else
  localparam logic [15:0] LDI_7FF_EXP  = 16'h07FF;
  localparam logic [15:0] ADDI_7FF_EXP = 16'h07FE;
`endif

  localparam int NUM_VECS = 15;

  vec_t        vecs [NUM_VECS];
  exp_t        sb_q [$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [10:0] model_pc;

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one instruction, check the combinational outputs, and queue the post-edge expectation.
  task automatic apply_stimulus(input vec_t v, input string tag);
    exp_t e;
    Data     = v.data;
    Out_Data = v.out_data;
    #1;
    check_value({tag, " WrRam"},   {31'b0, WrRam}, {31'b0, v.exp_wr});
    check_value({tag, " RdRam"},   {31'b0, RdRam}, {31'b0, v.exp_rd});
    check_value({tag, " Addr_DM"}, {21'b0, Addr_DM}, {21'b0, v.data[10:0]});
    check_value({tag, " Addr"},    {21'b0, Addr}, {21'b0, model_pc});
    model_pc = model_pc + 11'd1;
    e.pc  = model_pc;
    e.acc = v.exp_acc;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_value({tag, " next Addr"},    {21'b0, Addr}, {21'b0, e.pc});
      check_value({tag, " next In_Data"}, {16'b0, In_Data}, {16'b0, e.acc});
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input logic [15:0] d, input logic [15:0] od, input logic wr, input logic rd,
                         input logic [15:0] acc, input string tag);
    vec_t v;
    v.data = d; v.out_data = od; v.exp_wr = wr; v.exp_rd = rd; v.exp_acc = acc;
    apply_stimulus(v, tag);
    check_output(tag);
  endtask

  initial begin
    logic [15:0] junk [4];

    vecs[0]  = '{16'h1805, 16'h0000, 1'b0, 1'b0, 16'h0005};
    vecs[1]  = '{16'h2803, 16'h0000, 1'b0, 1'b0, 16'h0008};
    vecs[2]  = '{16'h3801, 16'h0000, 1'b0, 1'b0, 16'h0007};
    vecs[3]  = '{16'h0820, 16'h0000, 1'b1, 1'b0, 16'h0007};
    vecs[4]  = '{16'h1010, 16'h1234, 1'b0, 1'b1, 16'h1234};
    vecs[5]  = '{16'h2011, 16'h0F00, 1'b0, 1'b1, 16'h2134};
    vecs[6]  = '{16'h3012, 16'h3000, 1'b0, 1'b1, 16'hF134};
    vecs[7]  = '{16'h4123, 16'hFFFF, 1'b0, 1'b0, 16'hF134};
    vecs[8]  = '{16'hF800, 16'h0000, 1'b0, 1'b0, 16'hF134};
    vecs[9]  = '{16'h1FFF, 16'h0000, 1'b0, 1'b0, LDI_7FF_EXP};
    vecs[10] = '{16'h1BFF, 16'h0000, 1'b0, 1'b0, 16'h03FF};
    vecs[11] = '{16'h2000, 16'hFFFF, 1'b0, 1'b1, 16'h03FE};
    vecs[12] = '{16'h1800, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{16'h3801, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    vecs[14] = '{16'h2FFF, 16'h0000, 1'b0, 1'b0, ADDI_7FF_EXP};

    junk[0] = 16'h0820;
    junk[1] = 16'h1010;
    junk[2] = 16'h2803;
    junk[3] = 16'h3012;

    // Reset held with a STO on the bus: strobes must stay low.
    rst_n    = 1'b0;
    Data     = 16'h0820;
    Out_Data = 16'h0000;
    #1;
    check_value("reset Addr",    {21'b0, Addr}, 32'h0);
    check_value("reset In_Data", {16'b0, In_Data}, 32'h0);
    check_value("reset WrRam",   {31'b0, WrRam}, 32'h0);
    check_value("reset RdRam",   {31'b0, RdRam}, 32'h0);
    #1;
    rst_n    = 1'b1;
    model_pc = '0;

    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
      check_output($sformatf("vec%0d", i));
    end

    // Reset asserted during a STO aborts it.
    Data = 16'h0820;
    #1;
    check_value("pre-abort WrRam", {31'b0, WrRam}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_value("abort WrRam",   {31'b0, WrRam}, 32'h0);
    check_value("abort Addr",    {21'b0, Addr}, 32'h0);
    check_value("abort In_Data", {16'b0, In_Data}, 32'h0);
    @(posedge clk);
    #1;
    check_value("abort held Addr", {21'b0, Addr}, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = '0;

    // Program that halts at address 4.
    run_vec(16'h182A, 16'h0000, 1'b0, 1'b0, 16'h002A, "halt prog0");
    run_vec(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h002A, "halt prog1");
    run_vec(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h002A, "halt prog2");
    run_vec(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h002A, "halt prog3");
    Data = 16'h0000;
    #1;
    check_value("HLT Addr",  {21'b0, Addr}, 32'h4);
    check_value("HLT WrRam", {31'b0, WrRam}, 32'h0);
    check_value("HLT RdRam", {31'b0, RdRam}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      Data     = junk[$urandom_range(0, 3)];
      Out_Data = 16'h5555;
      #1;
      check_value($sformatf("halted%0d WrRam", c), {31'b0, WrRam}, 32'h0);
      check_value($sformatf("halted%0d RdRam", c), {31'b0, RdRam}, 32'h0);
      @(posedge clk);
      #1;
      check_value($sformatf("halted%0d Addr", c),    {21'b0, Addr}, 32'h4);
      check_value($sformatf("halted%0d In_Data", c), {16'b0, In_Data}, 32'h2A);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_value("unhalt Addr", {21'b0, Addr}, 32'h0);
    #2;
    rst_n    = 1'b1;
    model_pc = '0;
    run_vec(16'h1803, 16'h0000, 1'b0, 1'b0, 16'h0003, "post-halt LDI");

    // Run NOPs up to the top of program memory, then check the wrap.
    Data = 16'h4000;
    repeat (2046) @(posedge clk);
    @(negedge clk);
    check_value("pc top", {21'b0, Addr}, 32'h7FF);
    @(posedge clk);
    #1;
    check_value("pc wrap", {21'b0, Addr}, 32'h0);
    check_value("wrap In_Data", {16'b0, In_Data}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low: clk (clock), rst_n (reset).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Addr  output  11  program-memory address, equal to PC.
REQ-005 Data  input  16  instruction word from program memory, combinationally valid for the current Addr.
REQ-006 WrRam  output  1  data-memory write strobe.
REQ-007 RdRam  output  1  data-memory read strobe.
REQ-008 Addr_DM  output  11  data-memory address.
REQ-009 In_Data  output  16  write data to data memory.
REQ-010 Out_Data  input  16  read data from data memory, combinationally valid for the current Addr_DM.

Function
REQ-011 Instruction format SHALL be opcode = Data[15:11] and operand = Data[10:0].
REQ-012 Opcodes SHALL be: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI.
REQ-013 All other opcodes SHALL execute as NOP: PC advances, ACC unchanged, strobes low.
REQ-014 Execution SHALL be single-cycle: decode is combinational from Data, and ACC/PC update on the next rising clk.
REQ-015 Per-opcode ACC update SHALL be:
- STO: ACC unchanged.
- LD: ACC <= Out_Data.
- LDI: ACC <= imm.
- ADD: ACC <= ACC + Out_Data.
- ADDI: ACC <= ACC + imm.
- SUB: ACC <= ACC - Out_Data.
- SUBI: ACC <= ACC - imm.
REQ-016 imm SHALL be the 11-bit operand extended to 16 bits (see REQ-026).
REQ-017 Arithmetic SHALL be 16-bit modulo 2^16; carry/borrow are discarded and no flags are kept.
REQ-018 Addr_DM SHALL equal the operand for every opcode, and In_Data SHALL equal ACC at all times.
REQ-019 WrRam SHALL be 1 only during STO and RdRam SHALL be 1 only during LD, ADD and SUB; both are combinational, and they SHALL never be 1 simultaneously.
REQ-020 PC SHALL increment by 1 per cycle and wrap 2047 -> 0.
REQ-021 On HLT, PC SHALL hold, ACC SHALL hold, and an internal halted flag SHALL set.
REQ-022 While halted, PC and ACC SHALL be frozen and WrRam/RdRam forced to 0 regardless of Data, until reset.

Reset
REQ-023 rst_n=0 SHALL immediately force PC=0, ACC=0 and halted=0, so that Addr=0, In_Data=0, WrRam=0 and RdRam=0 while reset is held.
REQ-024 Reset asserted mid-program SHALL abort the current instruction; no write occurs on that edge.
REQ-025 After release, the first instruction SHALL be fetched from address 0 and execute on the first rising clk with rst_n=1.

Configuration
REQ-026 Macro MAIN_SIGN_EXTEND_EN:
- Defined: imm = {5{Data[10]}, Data[10:0]} (sign-extended).
- Undefined: imm = {5'b0, Data[10:0]} (zero-extended).
- All other behaviour is identical in both builds.

Verification
REQ-027 Reset, then Data=0x1805 (LDI 5) -> after 1 clk: In_Data=0x0005, Addr=1.
REQ-028 ACC=5, Data=0x2803 (ADDI 3) then 0x3801 (SUBI 1) -> In_Data=0x0008, then 0x0007.
REQ-029 ACC=7, Data=0x0820 (STO 0x020) -> WrRam=1, RdRam=0, Addr_DM=0x020, In_Data=0x0007 during that cycle.
REQ-030 Data=0x1010 (LD 0x010), Out_Data=0x1234 -> RdRam=1, Addr_DM=0x010; next cycle In_Data=0x1234.
REQ-031 Data=0x1FFF (LDI 0x7FF) -> In_Data=0xFFFF with MAIN_SIGN_EXTEND_EN defined, 0x07FF without.
REQ-032 Data=0x0000 (HLT) at Addr=4 -> Addr stays 4 and strobes stay 0 for 10 clks with any Data; rst_n pulse low -> Addr=0.
